// File: rtl/onehot_index_encoder_if.sv
// onehot_index_encoder_if
//   Request + index-stream bundle for onehot_index_encoder.
//   start/din       : encode request (din latched on accepted start)
//   out_valid/out_index/out_ready : index stream, one handshake per index
// Modports:
//   master : the encoder (consumes the request, sources the index stream)
//   slave  : the requester/consumer side
interface onehot_index_encoder_if;
  logic       start;
  logic [7:0] din;
  logic       out_valid;
  logic [2:0] out_index;
  logic       out_ready;

  modport master (
    input  start, din, out_ready,
    output out_valid, out_index
  );

  modport slave (
    output start, din, out_ready,
    input  out_valid, out_index
  );
endinterface

// File: rtl/onehot_index_encoder.sv
// onehot_index_encoder
//   Turns an 8-bit vector into the stream of 3-bit indices that rebuilds it
//   under the LED toggle-decode rule (index 0 -> bit 7, index 7 -> bit 0),
//   highest set bit first. Emitted indices are logged in an 8-entry table.
// Ports:
//   clk, rst      : clock, async active-high reset
//   bus (master)  : start/din request, out_valid/out_index/out_ready stream
//   busy, done    : busy in SCAN/DONE, done is a one-cycle end pulse
//   count, parity : indices emitted in current/last encode, count[0]
//   rd_addr/rd_data : registered table read port (1-cycle latency)
//   pb1, led      : LED select, registered LED value
module onehot_index_encoder (
  input  logic                          clk,
  input  logic                          rst,
  onehot_index_encoder_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    count,
  output logic                          parity,
  input  logic [2:0]                    rd_addr,
  output logic [2:0]                    rd_data,
  input  logic                          pb1,
  output logic [7:0]                    led
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] work_q, work_d;
  logic [3:0] count_q, count_d;
  logic [2:0] rd_data_q, rd_data_d;
  logic [7:0] led_q, led_d;
  logic [2:0] mem_q [8];

  logic [2:0] hi_pos;
  logic [2:0] cur_index;
  logic       hs;
  logic       mem_we;

  // Highest set bit of the remaining work. With work empty this falls back
  // to 7, so out_index idles at 0 (matches the reset value).
  always_comb begin
    hi_pos = 3'd7;
    for (int i = 0; i < 8; i++)
      if (work_q[i]) hi_pos = 3'(i);
  end

  assign cur_index = ~hi_pos;  // 7 - hi_pos
  assign hs        = (state_q == SCAN) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    work_d  = work_q;
    count_d = count_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vec_d   = bus.din;
          work_d  = bus.din;
          count_d = 4'd0;
          state_d = (bus.din != 8'd0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (hs) begin
          mem_we  = 1'b1;
          count_d = count_q + 4'd1;
          work_d  = work_q & ~(8'h01 << hi_pos);
          if (work_d == 8'd0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LED reflects registered vec/parity, so it trails them by one cycle.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    led_d     = pb1 ? {7'd0, count_q[0]} : vec_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= 8'd0;
      work_q    <= 8'd0;
      count_q   <= 4'd0;
      rd_data_q <= 3'd0;
      led_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      work_q    <= work_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      led_q     <= led_d;
    end
  end

  // Table is not reset; a same-cycle read of the written entry sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[2:0]] <= cur_index;
  end

  assign bus.out_valid = (state_q == SCAN);
  assign bus.out_index = cur_index;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign count         = count_q;
  assign parity        = count_q[0];
  assign rd_data       = rd_data_q;
  assign led           = led_q;

endmodule

// File: tb/tb_onehot_index_encoder.sv
module tb_onehot_index_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, done, parity, pb1;
  logic [3:0] count;
  logic [2:0] rd_addr, rd_data;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  onehot_index_encoder_if bus ();

  onehot_index_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .parity  (parity),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pb1     (pb1),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Expected index stream: first index in the top nibble, then downwards.
  typedef struct {
    logic [7:0]  din;
    int          k;
    logic [31:0] idx;
    logic        par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full encode with out_ready held high; all sampling on the falling edge.
  task automatic encode(input vec_t v);
    logic [31:0] e;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    bus.start = 1'b1; bus.din = v.din; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < v.k; j++) begin
      e = {28'd0, v.idx[31-4*j -: 4]};
      chk($sformatf("valid din=%0h j=%0d", v.din, j), {31'd0, bus.out_valid}, 1);
      chk($sformatf("index din=%0h j=%0d", v.din, j), {29'd0, bus.out_index}, e);
      chk($sformatf("early_done din=%0h j=%0d", v.din, j), {31'd0, done}, 0);
      @(negedge clk);
    end
    chk($sformatf("done din=%0h", v.din), {31'd0, done}, 1);
    chk($sformatf("valid_off din=%0h", v.din), {31'd0, bus.out_valid}, 0);
    chk($sformatf("count din=%0h", v.din), {28'd0, count}, 32'(v.k));
    chk($sformatf("parity din=%0h", v.din), {31'd0, parity}, {31'd0, v.par});
    @(negedge clk);
    chk($sformatf("done_pulse din=%0h", v.din), {31'd0, done}, 0);
    chk($sformatf("busy_low din=%0h", v.din), {31'd0, busy}, 0);
    for (int a = 0; a < v.k; a++) begin
      rd_addr = 3'(a);
      @(negedge clk);
      chk($sformatf("mem din=%0h a=%0d", v.din, a), {29'd0, rd_data}, {28'd0, v.idx[31-4*a -: 4]});
    end
    pb1 = 1'b0;
    @(negedge clk);
    chk($sformatf("led_vec din=%0h", v.din), {24'd0, led}, {24'd0, v.din});
    pb1 = 1'b1;
    @(negedge clk);
    chk($sformatf("led_par din=%0h", v.din), {24'd0, led}, {31'd0, v.par});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = '{din: 8'h8D, k: 4, idx: 32'h0457_0000, par: 1'b0};
    tbl[1] = '{din: 8'hFF, k: 8, idx: 32'h0123_4567, par: 1'b0};
    tbl[2] = '{din: 8'h01, k: 1, idx: 32'h7000_0000, par: 1'b1};
    tbl[3] = '{din: 8'h10, k: 1, idx: 32'h3000_0000, par: 1'b1};
    tbl[4] = '{din: 8'h42, k: 2, idx: 32'h1600_0000, par: 1'b0};
    tbl[5] = '{din: 8'h00, k: 0, idx: 32'h0000_0000, par: 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.din = 8'h00; bus.out_ready = 1'b0;
    rd_addr = 3'd0; pb1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",  {31'd0, bus.out_valid}, 0);
    chk("rst_index",  {29'd0, bus.out_index}, 0);
    chk("rst_busy",   {31'd0, busy}, 0);
    chk("rst_done",   {31'd0, done}, 0);
    chk("rst_count",  {28'd0, count}, 0);
    chk("rst_parity", {31'd0, parity}, 0);
    chk("rst_rddata", {29'd0, rd_data}, 0);
    chk("rst_led",    {24'd0, led}, 0);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) encode(tbl[t]);

    // Backpressure: 0x81 with out_ready low for the first three valid cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'h81; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp_valid s=%0d", s), {31'd0, bus.out_valid}, 1);
      chk($sformatf("bp_hold s=%0d", s),  {29'd0, bus.out_index}, 0);
      chk($sformatf("bp_done s=%0d", s),  {31'd0, done}, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk("bp_first", {29'd0, bus.out_index}, 0);
    @(negedge clk);
    chk("bp_second", {29'd0, bus.out_index}, 7);
    chk("bp_second_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("bp_done", {31'd0, done}, 1);
    chk("bp_count", {28'd0, count}, 2);

    // Start pulse during SCAN with a different din must be ignored.
    pb1 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'h8D;
    @(negedge clk);
    bus.din = 8'hFF;  // start still high, now in SCAN
    chk("ign_i0", {29'd0, bus.out_index}, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_i1", {29'd0, bus.out_index}, 4);
    @(negedge clk);
    chk("ign_i2", {29'd0, bus.out_index}, 5);
    @(negedge clk);
    chk("ign_i3", {29'd0, bus.out_index}, 7);
    @(negedge clk);
    chk("ign_done",  {31'd0, done}, 1);
    chk("ign_count", {28'd0, count}, 4);
    chk("ign_led",   {24'd0, led}, 8'h8D);

    // Reset after the second handshake of 0xF0.
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'hF0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mr_i0", {29'd0, bus.out_index}, 0);
    @(negedge clk);
    chk("mr_i1", {29'd0, bus.out_index}, 1);
    @(negedge clk);
    chk("mr_i2", {29'd0, bus.out_index}, 2);
    chk("mr_led_pre", {24'd0, led}, 8'hF0);
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'd0, bus.out_valid}, 0);
    chk("mr_count", {28'd0, count}, 0);
    chk("mr_led",   {24'd0, led}, 0);
    chk("mr_busy",  {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b1; bus.din = 8'h10;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mr_new_valid", {31'd0, bus.out_valid}, 1);
    chk("mr_new_index", {29'd0, bus.out_index}, 3);
    @(negedge clk);
    chk("mr_new_done",  {31'd0, done}, 1);
    chk("mr_new_count", {28'd0, count}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
